// File: rtl/z80_bus_ctrl.sv
// Z80 bus-cycle generator: turns the core's one-hot M-cycle/T-state and
// cycle qualifiers into registered bus strobes, inserts per-cycle-type
// internal wait states merged with the external wait, and latches read data.
module z80_bus_ctrl #(
  parameter int unsigned T2WRITE  = 1,
  parameter int unsigned REFRESH  = 0,
  parameter int unsigned M1_WAIT  = 0,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1,
  parameter int unsigned DW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cen,
  input  logic [6:0]    mcycle,
  input  logic [6:0]    tstate,
  input  logic          intcycle_n,
  input  logic          no_read,
  input  logic          write,
  input  logic          iorq,
  input  logic          wait_n,
  input  logic [DW-1:0] di,
  output logic          core_wait_n,
  output logic [DW-1:0] di_reg,
  output logic          mreq_n,
  output logic          iorq_n,
  output logic          rd_n,
  output logic          wr_n,
  output logic          wstate
);

  localparam logic [3:0] M1W  = 4'(M1_WAIT);
  localparam logic [3:0] MEMW = 4'(MEM_WAIT);
  localparam logic [3:0] IOW  = 4'(IO_WAIT);

  logic [3:0]    wcnt_q, wcnt_d;
  logic          mreq_n_d, iorq_n_d, rd_n_d, wr_n_d;
  logic [DW-1:0] di_reg_d;
  logic          m1, act;
  logic          unused_bits;

  // Only M1, T1..T3 are decoded; the remaining one-hot bits are don't-care.
  assign unused_bits = ^{mcycle[6:1], tstate[6:4], tstate[0]};

  assign wstate      = (wcnt_q != 4'd0);
  assign core_wait_n = wait_n & ~wstate;
  assign m1          = mcycle[0];
  // Strobes are (re)asserted on the T1 edge and on every T2 edge that stalls.
  assign act         = tstate[1] | (tstate[2] & ~core_wait_n);

  // Wait counter: load by cycle type in T1, count down in T2.
  always_comb begin
    wcnt_d = wcnt_q;
    if (tstate[1]) begin
      if (m1) begin
        wcnt_d = intcycle_n ? M1W : IOW;
      end else if (iorq) begin
        wcnt_d = IOW;
      end else if (no_read && !write) begin
        wcnt_d = 4'd0;
      end else begin
        wcnt_d = MEMW;
      end
    end else if (tstate[2] && wstate) begin
      wcnt_d = wcnt_q - 4'd1;
    end
  end

  // Strobe next state: all high unless a rule below pulls one low.
  always_comb begin
    mreq_n_d = 1'b1;
    iorq_n_d = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    if (m1) begin
      if (act) begin
        rd_n_d   = ~intcycle_n;
        mreq_n_d = ~intcycle_n;
        iorq_n_d = intcycle_n;
      end
      if (tstate[3] && (REFRESH != 0)) begin
        mreq_n_d = 1'b0;
      end
    end else begin
      if (act && !no_read && !write) begin
        rd_n_d   = 1'b0;
        iorq_n_d = ~iorq;
        mreq_n_d = iorq;
      end
      // Late writes start on the first T2 edge so data has a cycle to settle.
      if (write && ((T2WRITE != 0) ? act : tstate[2])) begin
        wr_n_d   = 1'b0;
        iorq_n_d = ~iorq;
        mreq_n_d = iorq;
      end
    end
  end

  // Capture read data on the final T2 edge, once all waits are done.
  always_comb begin
    di_reg_d = di_reg;
    if (tstate[2] && core_wait_n) begin
      di_reg_d = di;
    end
  end

  // State registers; everything holds while cen is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= 4'd0;
      mreq_n <= 1'b1;
      iorq_n <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      di_reg <= '0;
    end else if (cen) begin
      wcnt_q <= wcnt_d;
      mreq_n <= mreq_n_d;
      iorq_n <= iorq_n_d;
      rd_n   <= rd_n_d;
      wr_n   <= wr_n_d;
      di_reg <= di_reg_d;
    end
  end

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Bench for z80_bus_ctrl: two differently parameterised instances share the
// bus inputs; each gets its own T-state sequence. Expected outputs per cen
// period come from a cycle-level model of the bus timing rules.
module tb_z80_bus_ctrl;

  localparam int unsigned A_T2W = 0, A_REF = 1, A_M1 = 0, A_MEM = 2, A_IO = 1;
  localparam int unsigned B_T2W = 1, B_REF = 0, B_M1 = 3, B_MEM = 1, B_IO = 1;

  logic       clk = 1'b0;
  logic       reset, cen, intcycle_n, no_read, write, iorq, wait_n;
  logic [6:0] mcycle, tstate_a, tstate_b;
  logic [7:0] di;
  logic       cw_a, mreq_a, iorq_a, rd_a, wr_a, ws_a;
  logic       cw_b, mreq_b, iorq_b, rd_b, wr_b, ws_b;
  logic [7:0] dr_a, dr_b;

  always #5 clk = ~clk;

  z80_bus_ctrl #(
    .T2WRITE(A_T2W), .REFRESH(A_REF), .M1_WAIT(A_M1), .MEM_WAIT(A_MEM), .IO_WAIT(A_IO), .DW(8)
  ) u_dut_a (
    .clk(clk), .reset(reset), .cen(cen), .mcycle(mcycle), .tstate(tstate_a),
    .intcycle_n(intcycle_n), .no_read(no_read), .write(write), .iorq(iorq), .wait_n(wait_n),
    .di(di), .core_wait_n(cw_a), .di_reg(dr_a), .mreq_n(mreq_a), .iorq_n(iorq_a),
    .rd_n(rd_a), .wr_n(wr_a), .wstate(ws_a)
  );

  z80_bus_ctrl #(
    .T2WRITE(B_T2W), .REFRESH(B_REF), .M1_WAIT(B_M1), .MEM_WAIT(B_MEM), .IO_WAIT(B_IO), .DW(8)
  ) u_dut_b (
    .clk(clk), .reset(reset), .cen(cen), .mcycle(mcycle), .tstate(tstate_b),
    .intcycle_n(intcycle_n), .no_read(no_read), .write(write), .iorq(iorq), .wait_n(wait_n),
    .di(di), .core_wait_n(cw_b), .di_reg(dr_b), .mreq_n(mreq_b), .iorq_n(iorq_b),
    .rd_n(rd_b), .wr_n(wr_b), .wstate(ws_b)
  );

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] mdl_di_a, mdl_di_b;
  logic [13:0] obs_a [32];
  logic [13:0] obs_b [32];
  logic [7:0] di_arr [32];
  int         n_a, n_b, s_a, s_b, np;

  // Packed view: {core_wait_n, wstate, mreq_n, iorq_n, rd_n, wr_n, di_reg}
  function automatic logic [13:0] pk_a();
    return {cw_a, ws_a, mreq_a, iorq_a, rd_a, wr_a, dr_a};
  endfunction

  function automatic logic [13:0] pk_b();
    return {cw_b, ws_b, mreq_b, iorq_b, rd_b, wr_b, dr_b};
  endfunction

  // kind: 0 = M1, 1 = read, 2 = write, 3 = internal (no read, no write)
  function automatic int n_waits(input int m1w, input int memw, input int iow, input int kind,
                                 input logic io, input logic intn);
    if (kind == 0) return intn ? m1w : iow;
    if (io) return iow;
    if (kind == 3) return 0;
    return memw;
  endfunction

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Core T-state for period p of a cycle with s stall periods in T2.
  function automatic logic [6:0] tst(input int p, input int s, input int kind);
    if (p == 0) return 7'h02;
    if (p <= s + 1) return 7'h04;
    if (p == s + 2) return 7'h08;
    if (p == s + 3 && kind == 0) return 7'h10;
    return 7'h00;
  endfunction

  // Expected outputs during period p (period 0 = T1, 1..s+1 = T2, then T3, T4).
  function automatic logic [13:0] model_out(input int t2w, input int refr, input int n,
                                            input int s, input int p, input int kind,
                                            input logic io, input logic intn, input int e,
                                            input logic [7:0] di_old, input logic [7:0] di_new);
    int         j, wc;
    logic       in_t2, wn, cw, ws, mq, iq, rd, wr, wr_win;
    logic [7:0] d;
    in_t2 = (p >= 1) && (p <= s + 1);
    j     = p - 1;
    wc    = (in_t2 && n > j) ? n - j : 0;
    ws    = (wc != 0);
    wn    = !(in_t2 && j < e);
    cw    = wn && !ws;
    d     = (p >= s + 2) ? di_new : di_old;
    mq = 1'b1; iq = 1'b1; rd = 1'b1; wr = 1'b1;
    if (kind == 0) begin
      if (in_t2) begin
        if (intn) begin rd = 1'b0; mq = 1'b0; end
        else iq = 1'b0;
      end
      if (refr != 0 && p == s + 3) mq = 1'b0;
    end else if (kind == 1) begin
      if (in_t2) begin
        rd = 1'b0;
        if (io) iq = 1'b0; else mq = 1'b0;
      end
    end else if (kind == 2) begin
      wr_win = (t2w != 0) ? in_t2 : (p >= 2 && p <= s + 2);
      if (wr_win) begin
        wr = 1'b0;
        if (io) iq = 1'b0; else mq = 1'b0;
      end
    end
    return {cw, ws, mq, iq, rd, wr, d};
  endfunction

  // Drive one bus cycle into both instances and record outputs per period.
  // mode: 0 = cen every clock, 1 = cen at 50% duty, 2 = random cen gaps.
  task automatic run_cycle(input int kind, input logic io, input logic intn, input int e,
                           input int mode);
    int extra;
    n_a = n_waits(A_M1, A_MEM, A_IO, kind, io, intn);
    n_b = n_waits(B_M1, B_MEM, B_IO, kind, io, intn);
    s_a = max2(n_a, e);
    s_b = max2(n_b, e);
    np  = max2(s_a, s_b) + 3 + ((kind == 0) ? 1 : 0) + 1;
    mcycle     = (kind == 0) ? 7'h01 : 7'(1 << $urandom_range(1, 6));
    intcycle_n = (kind == 0) ? intn : 1'b1;
    iorq       = (kind == 0) ? 1'b0 : io;
    write      = (kind == 2);
    no_read    = (kind == 3) ? 1'b1 : (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int p = 0; p < np; p++) begin
      di_arr[p] = 8'($urandom_range(1, 255));
      di        = di_arr[p];
      wait_n    = !(p >= 1 && p <= e);
      tstate_a  = tst(p, s_a, kind);
      tstate_b  = tst(p, s_b, kind);
      extra     = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 2);
      for (int k = 0; k < extra; k++) begin
        cen = 1'b0;
        @(posedge clk); #1;
      end
      #1;
      obs_a[p] = pk_a();
      obs_b[p] = pk_b();
      cen = 1'b1;
      @(posedge clk); #1;
    end
    tstate_a = 7'h00;
    tstate_b = 7'h00;
    wait_n   = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cen = 1'b0; mcycle = 7'h01; tstate_a = 7'h00; tstate_b = 7'h00;
    intcycle_n = 1'b1; no_read = 1'b0; write = 1'b0; iorq = 1'b0; wait_n = 1'b0; di = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (pk_a() !== 14'h0F00) begin
      mismatched++; $display("FAIL reset_wait_low dut_a: got %h want %h", pk_a(), 14'h0F00);
    end
    wait_n = 1'b1; #1;
    compared++;
    if (pk_b() !== 14'h2F00) begin
      mismatched++; $display("FAIL reset_state dut_b: got %h want %h", pk_b(), 14'h2F00);
    end
    @(posedge clk); #1;
    reset = 1'b0; cen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compared++;
      if (pk_a() !== 14'h2F00 || pk_b() !== 14'h2F00) begin
        mismatched++;
        $display("FAIL reset_release edge %0d: got %h/%h want %h", i, pk_a(), pk_b(), 14'h2F00);
      end
    end
    mdl_di_a = 8'h00;
    mdl_di_b = 8'h00;
  endtask

  task automatic test_directed();
    int kinds [9] = '{0, 1, 1, 2, 2, 0, 1, 3, 0};
    int ios   [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    int intns [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 1};
    int exts  [9] = '{0, 0, 3, 0, 0, 0, 2, 0, 1};
    logic [13:0] exp_a, exp_b;
    for (int mode = 0; mode < 2; mode++) begin
      for (int c = 0; c < 9; c++) begin
        run_cycle(kinds[c], 1'(ios[c]), 1'(intns[c]), exts[c], mode);
        for (int p = 0; p < np; p++) begin
          exp_a = model_out(A_T2W, A_REF, n_a, s_a, p, kinds[c], 1'(ios[c]), 1'(intns[c]),
                            exts[c], mdl_di_a, di_arr[s_a + 1]);
          exp_b = model_out(B_T2W, B_REF, n_b, s_b, p, kinds[c], 1'(ios[c]), 1'(intns[c]),
                            exts[c], mdl_di_b, di_arr[s_b + 1]);
          compared++;
          if (obs_a[p] !== exp_a) begin
            mismatched++;
            $display("FAIL directed dut_a mode%0d cyc%0d p%0d: got %h want %h",
                     mode, c, p, obs_a[p], exp_a);
          end
          compared++;
          if (obs_b[p] !== exp_b) begin
            mismatched++;
            $display("FAIL directed dut_b mode%0d cyc%0d p%0d: got %h want %h",
                     mode, c, p, obs_b[p], exp_b);
          end
        end
        mdl_di_a = di_arr[s_a + 1];
        mdl_di_b = di_arr[s_b + 1];
      end
    end
  endtask

  task automatic test_reset_mid();
    mcycle = 7'h02; intcycle_n = 1'b1; no_read = 1'b0; write = 1'b0; iorq = 1'b0;
    wait_n = 1'b1; di = 8'h5A; cen = 1'b1;
    tstate_a = 7'h02; tstate_b = 7'h02;
    @(posedge clk); #1;
    tstate_a = 7'h04; tstate_b = 7'h04;
    @(posedge clk); #1;
    compared++;
    if (rd_a !== 1'b0 || rd_b !== 1'b0 || ws_a !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_read_pre: got rd %b/%b ws_a %b want 0/0 1", rd_a, rd_b, ws_a);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (pk_a() !== 14'h2F00 || pk_b() !== 14'h2F00) begin
      mismatched++;
      $display("FAIL mid_read_reset: got %h/%h want %h", pk_a(), pk_b(), 14'h2F00);
    end
    tstate_a = 7'h00; tstate_b = 7'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compared++;
      if (pk_a() !== 14'h2F00 || pk_b() !== 14'h2F00) begin
        mismatched++;
        $display("FAIL mid_read_release edge %0d: got %h/%h want %h",
                 i, pk_a(), pk_b(), 14'h2F00);
      end
    end
    mdl_di_a = 8'h00;
    mdl_di_b = 8'h00;
  endtask

  task automatic test_back_to_back();
    int          kind, e;
    logic        io, intn;
    logic [13:0] exp_a, exp_b;
    for (int c = 0; c < 40; c++) begin
      kind = $urandom_range(0, 3);
      io   = 1'($urandom_range(0, 1));
      intn = ($urandom_range(0, 3) != 0);
      e    = $urandom_range(0, 4);
      run_cycle(kind, io, intn, e, 2);
      if (kind == 0) io = 1'b0;
      for (int p = 0; p < np; p++) begin
        exp_a = model_out(A_T2W, A_REF, n_a, s_a, p, kind, io, intn, e, mdl_di_a,
                          di_arr[s_a + 1]);
        exp_b = model_out(B_T2W, B_REF, n_b, s_b, p, kind, io, intn, e, mdl_di_b,
                          di_arr[s_b + 1]);
        compared++;
        if (obs_a[p] !== exp_a) begin
          mismatched++;
          $display("FAIL random dut_a cyc%0d kind%0d p%0d: got %h want %h",
                   c, kind, p, obs_a[p], exp_a);
        end
        compared++;
        if (obs_b[p] !== exp_b) begin
          mismatched++;
          $display("FAIL random dut_b cyc%0d kind%0d p%0d: got %h want %h",
                   c, kind, p, obs_b[p], exp_b);
        end
      end
      mdl_di_a = di_arr[s_a + 1];
      mdl_di_b = di_arr[s_b + 1];
    end
  endtask

  initial begin
    assert (A_M1 <= 15 && A_MEM <= 15 && A_IO <= 15 && B_M1 <= 15 && B_MEM <= 15 && B_IO <= 15)
      else $fatal(1, "FAIL param_range: wait parameter above 15");
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
